// File: rtl/dram_pkg.sv
// Shared types for the banked DRAM responder: FSM states, access classes, latency helpers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_ACT,
        ST_CAS,
        ST_REFRESH
    } state_e;

    typedef enum logic [1:0] {
        ACC_HIT,
        ACC_EMPTY,
        ACC_CONFLICT
    } acc_e;

    // Width of the shared phase down-counter; comfortably covers any sane T_* value.
    localparam int CNT_W = 8;

    // Default timing and the accept-to-ready latencies it produces.
    localparam int DEF_T_CAS        = 2;
    localparam int DEF_T_RCD        = 3;
    localparam int DEF_T_RP         = 3;
    localparam int LAT_HIT_DEF      = DEF_T_CAS;
    localparam int LAT_EMPTY_DEF    = DEF_T_RCD + DEF_T_CAS;
    localparam int LAT_CONFLICT_DEF = DEF_T_RP + DEF_T_RCD + DEF_T_CAS;

    // Accept-to-ready latency for a given row-buffer outcome.
    function automatic int access_latency(input acc_e cls, input int t_cas,
                                          input int t_rcd, input int t_rp);
        case (cls)
            ACC_HIT:   return t_cas;
            ACC_EMPTY: return t_rcd + t_cas;
            default:   return t_rp + t_rcd + t_cas;
        endcase
    endfunction

endpackage

// File: rtl/dram_bank_tracker.sv
// Per-bank open-row state and hit/empty/conflict classification of a lookup address.
// Latency: classification is combinational; open/close updates take effect next edge.
// Backpressure: none; driven entirely by the owning FSM.
module dram_bank_tracker
    import dram_pkg::*;
#(
    parameter int BANK_BITS = 1,
    parameter int ROW_W     = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BANK_BITS-1:0] lk_bank,
    input  logic [ROW_W-1:0]     lk_row,
    output acc_e                 lk_cls,
    input  logic                 open_en,
    input  logic [BANK_BITS-1:0] open_bank,
    input  logic [ROW_W-1:0]     open_row,
    input  logic                 close_all
);

    localparam int NB = 1 << BANK_BITS;

    logic [NB-1:0] vld_q, vld_d;
    logic [ROW_W-1:0] row_q [NB];
    logic [ROW_W-1:0] row_d [NB];

    // Close-all (refresh) and open (end of activate) never coincide; open wins if they did.
    always_comb begin
        vld_d = vld_q;
        row_d = row_q;
        if (close_all) begin
            vld_d = '0;
        end
        if (open_en) begin
            vld_d[open_bank] = 1'b1;
            row_d[open_bank] = open_row;
        end
    end

    // Compare the lookup address against the addressed bank's row buffer.
    always_comb begin
        lk_cls = ACC_CONFLICT;
        if (!vld_q[lk_bank]) begin
            lk_cls = ACC_EMPTY;
        end else if (row_q[lk_bank] == lk_row) begin
            lk_cls = ACC_HIT;
        end
    end

    // Row-buffer state registers; reset closes every bank.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q <= '0;
            for (int i = 0; i < NB; i++) begin
                row_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/dram.sv
// Banked DRAM responder (open-page, per-bank row tracking); optional refresh under DRAM_REFRESH_EN.
// Latency: accept to ready-high is T_CAS (hit), T_RCD+T_CAS (empty), T_RP+T_RCD+T_CAS (conflict).
// Backpressure: ready low while busy or refreshing; re/we seen while ready is low are dropped.
module dram
    import dram_pkg::*;
#(
    parameter int ADDR_BITS        = 10,
    parameter int ROW_BITS         = 3,
    parameter int BANK_BITS        = 1,
    parameter int T_CAS            = DEF_T_CAS,
    parameter int T_RCD            = DEF_T_RCD,
    parameter int T_RP             = DEF_T_RP,
    parameter int REFRESH_INTERVAL = 64,
    parameter int T_RFC            = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] addr,
    input  logic [63:0] din,
    output logic [63:0] dout,
    input  logic        re,
    input  logic        we,
    output logic        ready
);

    localparam int ROW_W = ADDR_BITS - ROW_BITS - BANK_BITS;
    localparam int DEPTH = 1 << ADDR_BITS;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [63:0]          din_q, din_d;
    logic                 wr_q, wr_d;
    logic [63:0]          dout_q, dout_d;
    logic                 ready_q, ready_d;

    logic                 accept;
    logic                 cnt_done;
    logic                 refresh_due;
    logic                 enter_refresh;
    logic                 complete;
    logic                 mem_we;
    logic                 open_en;
    acc_e                 cls;
    logic [63:0]          rd_word;

    // Words are kept inverted so that zero-initialised storage reads back as all-ones.
    logic [63:0]          mem_inv [DEPTH];

    // Upper address bits alias by design.
    logic unused_addr;
    assign unused_addr = ^addr[63:ADDR_BITS];

    assign accept   = ready_q & (re | we);
    assign cnt_done = (cnt_q == '0);
    assign complete = (state_q == ST_CAS) && cnt_done;
    assign rd_word  = ~mem_inv[addr_q];

    dram_bank_tracker #(
        .BANK_BITS (BANK_BITS),
        .ROW_W     (ROW_W)
    ) u_tracker (
        .clk       (clk),
        .rst       (rst),
        .lk_bank   (addr[ROW_BITS +: BANK_BITS]),
        .lk_row    (addr[ADDR_BITS-1:ROW_BITS+BANK_BITS]),
        .lk_cls    (cls),
        .open_en   (open_en),
        .open_bank (addr_q[ROW_BITS +: BANK_BITS]),
        .open_row  (addr_q[ADDR_BITS-1:ROW_BITS+BANK_BITS]),
        .close_all (enter_refresh)
    );

`ifdef DRAM_REFRESH_EN
    localparam int RC_W = $clog2(REFRESH_INTERVAL + 1);

    logic [RC_W-1:0] rcnt_q, rcnt_d;
    logic            pend_q, pend_d;
    logic            tick;

    // Free-running interval counter; pending is held until refresh actually starts.
    always_comb begin
        tick   = (rcnt_q == RC_W'(REFRESH_INTERVAL - 1));
        rcnt_d = tick ? '0 : rcnt_q + RC_W'(1);
        pend_d = (pend_q | tick) & ~enter_refresh;
    end

    assign refresh_due = pend_q | tick;

    // Refresh bookkeeping registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rcnt_q <= '0;
            pend_q <= 1'b0;
        end else begin
            rcnt_q <= rcnt_d;
            pend_q <= pend_d;
        end
    end
`else
    logic [31:0] unused_refresh_par;
    assign unused_refresh_par = 32'(REFRESH_INTERVAL ^ T_RFC);
    assign refresh_due = 1'b0;
`endif

    // Next state and phase counter; the counter reloads on every state entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q - CNT_W'(1);
        case (state_q)
            ST_IDLE: begin
                cnt_d = cnt_q;
                if (refresh_due) begin
                    state_d = ST_REFRESH;
                    cnt_d   = CNT_W'(T_RFC - 1);
                end else if (accept) begin
                    case (cls)
                        ACC_HIT: begin
                            state_d = ST_CAS;
                            cnt_d   = CNT_W'(T_CAS - 1);
                        end
                        ACC_EMPTY: begin
                            state_d = ST_ACT;
                            cnt_d   = CNT_W'(T_RCD - 1);
                        end
                        default: begin
                            state_d = ST_PRE;
                            cnt_d   = CNT_W'(T_RP - 1);
                        end
                    endcase
                end
            end
            ST_PRE: begin
                if (cnt_done) begin
                    state_d = ST_ACT;
                    cnt_d   = CNT_W'(T_RCD - 1);
                end
            end
            ST_ACT: begin
                if (cnt_done) begin
                    state_d = ST_CAS;
                    cnt_d   = CNT_W'(T_CAS - 1);
                end
            end
            ST_CAS: begin
                if (cnt_done) begin
                    if (refresh_due) begin
                        state_d = ST_REFRESH;
                        cnt_d   = CNT_W'(T_RFC - 1);
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            ST_REFRESH: begin
                if (cnt_done) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Request latch, row-open/close strobes, completion effects and ready.
    always_comb begin
        addr_d        = addr_q;
        din_d         = din_q;
        wr_d          = wr_q;
        dout_d        = dout_q;
        ready_d       = (state_d == ST_IDLE);
        open_en       = (state_q == ST_ACT) && cnt_done;
        enter_refresh = (state_d == ST_REFRESH) && (state_q != ST_REFRESH);
        mem_we        = complete && wr_q && rst;
        if (state_q == ST_IDLE && accept && !refresh_due) begin
            addr_d = addr[ADDR_BITS-1:0];
            din_d  = din;
            wr_d   = we;
        end
        if (complete && !wr_q) begin
            dout_d = rd_word;
        end
    end

    // Control and datapath registers; reset drops any request in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            wr_q    <= 1'b0;
            dout_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            wr_q    <= wr_d;
            dout_q  <= dout_d;
            ready_q <= ready_d;
        end
    end

    // Storage write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_inv[addr_q] <= ~din_q;
        end
    end

    assign dout  = dout_q;
    assign ready = ready_q;

endmodule
